// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO read-side packer.
// Optional timeout flush is selected with FIFO_RD_PACKER_TIMEOUT_EN.
package fifo_pkg;

    localparam int DW     = 8;
    localparam int BYTES  = 4;
    localparam int FILL_W = $clog2(BYTES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        HOLD  = 2'd2,
        FLUSH = 2'd3
    } state_e;

    // Lane-valid mask with the lowest `lanes` bits set.
    function automatic logic [BYTES-1:0] keep_mask(input logic [FILL_W-1:0] lanes);
        logic [BYTES-1:0] mask;
        for (int i = 0; i < BYTES; i++) begin
            mask[i] = (i < int'(lanes));
        end
        return mask;
    endfunction

endpackage

// File: rtl/fifo_rd_packer_pack_timer.sv
// Idle-cycle counter for the packer's partial-word flush; present only
// when FIFO_RD_PACKER_TIMEOUT_EN is defined.
`ifdef FIFO_RD_PACKER_TIMEOUT_EN
module pack_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic hit
);
    import fifo_pkg::*;

    localparam int            CW    = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] count_q, count_d;

    // Saturates at the limit so a late flush still sees the hit.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && count_q != LIMIT) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign hit = (count_q == LIMIT);

endmodule
`endif

// File: rtl/fifo_rd_packer.sv
// Drains bytes from the async FIFO read port and packs them little-endian
// into words on a valid/ready master. FIFO_RD_PACKER_TIMEOUT_EN adds idle flush.
module fifo_rd_packer #(
    parameter int BYTES = fifo_pkg::BYTES,
    parameter int DW    = fifo_pkg::DW
`ifdef FIFO_RD_PACKER_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 16
`endif
) (
    input  logic                  r_clk,
    input  logic                  rst_n,
    input  logic                  r_empty,
    output logic                  r_en,
    input  logic [DW-1:0]         r_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [BYTES*DW-1:0]   m_data,
    output logic [BYTES-1:0]      m_keep
);
    import fifo_pkg::*;

    localparam int            FW       = $clog2(BYTES + 1);
    localparam logic [FW-1:0] FULL     = FW'(BYTES);
    localparam logic [FW:0]   FULL_SUM = (FW + 1)'(BYTES);

    logic [BYTES*DW-1:0] acc_q, acc_d, acc_wr;
    logic [FW-1:0]       fill_q, fill_d;
    logic                pend_q, pend_d;
    logic [BYTES*DW-1:0] m_data_q, m_data_d;
    logic [BYTES-1:0]    m_keep_q, m_keep_d;
    logic                m_valid_q, m_valid_d;
    state_e              state_q, state_d;

    logic                out_free;
    logic [FW:0]         fill_sum;
    logic                room;
    logic                complete;
    logic                move;

`ifdef FIFO_RD_PACKER_TIMEOUT_EN
    logic partial;
    logic flush;
    logic flush_wait;
    logic tmr_clear;
    logic tmr_enable;
    logic tmr_hit;

    pack_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_pack_timer (
        .clk    (r_clk),
        .rst_n  (rst_n),
        .clear  (tmr_clear),
        .enable (tmr_enable),
        .hit    (tmr_hit)
    );
`endif

    // A read is allowed if the byte it returns has a lane to land in,
    // counting the byte already in flight.
    always_comb begin
        out_free = !m_valid_q || m_ready;
        fill_sum = {1'b0, fill_q} + {{FW{1'b0}}, pend_q};
        room     = (fill_sum < FULL_SUM) || ((fill_sum == FULL_SUM) && out_free);
        r_en     = rst_n && !r_empty && room;
    end

    always_comb begin
        acc_wr = acc_q;
        for (int i = 0; i < BYTES; i++) begin
            if (pend_q && int'(fill_q) == i) begin
                acc_wr[i*DW +: DW] = r_data;
            end
        end

        acc_d     = acc_wr;
        fill_d    = fill_q + FW'(pend_q);
        pend_d    = r_en;
        m_data_d  = m_data_q;
        m_keep_d  = m_keep_q;
        m_valid_d = m_valid_q && !m_ready;

        // The last byte arriving completes the word in the same cycle,
        // which is what keeps the stream bubble-free.
        complete = (pend_q && fill_sum == FULL_SUM) || (state_q == HOLD);
        move     = complete && out_free;

`ifdef FIFO_RD_PACKER_TIMEOUT_EN
        partial    = (fill_q != '0) && (fill_q != FULL);
        flush      = tmr_hit && partial && !pend_q && out_free;
        flush_wait = tmr_hit && partial && !pend_q && !out_free && !r_en;
        tmr_enable = partial && !pend_q && !r_en;
        tmr_clear  = pend_q || !partial || flush;
`endif

        if (move) begin
            m_data_d  = acc_wr;
            m_keep_d  = '1;
            m_valid_d = 1'b1;
            acc_d     = '0;
            fill_d    = '0;
        end
`ifdef FIFO_RD_PACKER_TIMEOUT_EN
        else if (flush) begin
            m_data_d  = acc_q;
            m_keep_d  = keep_mask(fill_q);
            m_valid_d = 1'b1;
            acc_d     = '0;
            fill_d    = '0;
        end
`endif

        state_d = FILL;
        if (fill_d == FULL) begin
            state_d = HOLD;
        end
`ifdef FIFO_RD_PACKER_TIMEOUT_EN
        else if (flush_wait) begin
            state_d = FLUSH;
        end
`endif
        else if (fill_d == '0 && !r_en) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge r_clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            fill_q    <= '0;
            pend_q    <= 1'b0;
            m_data_q  <= '0;
            m_keep_q  <= '0;
            m_valid_q <= 1'b0;
            state_q   <= IDLE;
        end else begin
            acc_q     <= acc_d;
            fill_q    <= fill_d;
            pend_q    <= pend_d;
            m_data_q  <= m_data_d;
            m_keep_q  <= m_keep_d;
            m_valid_q <= m_valid_d;
            state_q   <= state_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_keep  = m_keep_q;

endmodule
